// File: rtl/fifo_stream_reader_if.sv
// Stream-reader bundle: FIFO-side take/empty/data plus valid/ready output stream.
// master: the reader (drives take and the stream); slave: the FIFO/consumer side.
// Ports: in_enable, in_fifo_empty, in_fifo_data, in_ready in; out_fifo_take, out_valid, out_data, out_busy, out_word_count out.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic                   in_enable;
  logic                   in_fifo_empty;
  logic [DATA_WIDTH-1:0]  in_fifo_data;
  logic                   out_fifo_take;
  logic                   out_valid;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   in_ready;
  logic                   out_busy;
  logic [COUNT_WIDTH-1:0] out_word_count;

  modport master (
    input  in_enable, in_fifo_empty, in_fifo_data, in_ready,
    output out_fifo_take, out_valid, out_data, out_busy, out_word_count
  );

  modport slave (
    output in_enable, in_fifo_empty, in_fifo_data, in_ready,
    input  out_fifo_take, out_valid, out_data, out_busy, out_word_count
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Purpose: pops a FIFO (controller + sync-read RAM) and presents words on a valid/ready stream via a 2-entry skid buffer.
// Latency: take in cycle N, data sampled N+1, out_valid in N+2; one word per cycle when in_ready stays high.
// Backpressure: in_ready low lets at most 2 further takes land in the buffer, then take stalls until a pop frees space.
// Ports: in_clock, in_reset_n (async active-low) plain; everything else through fifo_stream_reader_if.master.
module fifo_stream_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input logic                 in_clock,
  input logic                 in_reset_n,
  fifo_stream_reader_if.master bus
);

  logic [1:0]             occ;
  logic                   inflight;
  logic                   run;
  logic [DATA_WIDTH-1:0]  ent0;
  logic [DATA_WIDTH-1:0]  ent1;
  logic [COUNT_WIDTH-1:0] count;

  logic       pop;
  logic [1:0] used;
  logic [1:0] slot;
  logic       take;

  always_comb begin
    pop  = (occ != 2'd0) & bus.in_ready;
    // Slots committed after this edge; occ + inflight never exceeds 2, so 2 bits suffice.
    used = occ + {1'b0, inflight} - {1'b0, pop};
    // Landing slot for an in-flight word once the head (if popped) has shifted out.
    slot = occ - {1'b0, pop};
    // Free space (2 - used) of at least one slot is required to issue a take.
    take = run & bus.in_enable & ~bus.in_fifo_empty & (used <= 2'd1);
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      run      <= 1'b0;
      ent0     <= '0;
      ent1     <= '0;
      count    <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= take;
      occ      <= used;
      count    <= count + COUNT_WIDTH'(pop);
      if (pop && occ == 2'd2) begin
        ent0 <= ent1;
      end
      // A capture into slot 0 only happens when the buffer empties this edge,
      // so it never collides with the shift above.
      if (inflight) begin
        if (slot == 2'd0) begin
          ent0 <= bus.in_fifo_data;
        end else begin
          ent1 <= bus.in_fifo_data;
        end
      end
    end
  end

  assign bus.out_fifo_take  = take;
  assign bus.out_valid      = (occ != 2'd0);
  assign bus.out_data       = ent0;
  assign bus.out_busy       = (occ != 2'd0) | inflight;
  assign bus.out_word_count = count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model feeds words, scoreboard monitor checks the stream.
// Stimulus pushes each loaded word into an expected queue; the monitor pops it on every transfer.
// Ports: drives the slave side of fifo_stream_reader_if plus clk/rst_n.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) bus ();

  fifo_stream_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .in_clock   (clk),
    .in_reset_n (rst_n),
    .bus        (bus.master)
  );

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  ntakes = 0;
  int  first_take = -1;
  int  last_take = -1;
  int  npops = 0;
  int  first_pop = -1;
  int  last_pop = -1;
  bit  hold_empty = 1'b0;
  logic take_s;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  task automatic update_empty();
    bus.in_fifo_empty = (fq.size() == 0) || hold_empty;
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    update_empty();
  endtask

  // One clock: sample take before the edge, model the RAM read after it.
  task automatic tick();
    @(negedge clk);
    take_s = bus.out_fifo_take;
    @(posedge clk);
    #1;
    if (take_s) begin
      if (fq.size() == 0) begin
        check("take_while_empty", 1, 0);
      end else begin
        bus.in_fifo_data = fq.pop_front();
      end
      ntakes++;
      if (first_take < 0) first_take = cyc;
      last_take = cyc;
    end
    cyc++;
    update_empty();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_marks();
    first_take = -1;
    last_take  = -1;
    first_pop  = -1;
    last_pop   = -1;
  endtask

  int t0, p0, rel_cyc;

  initial begin
    rst_n            = 1'b0;
    bus.in_enable    = 1'b1;
    bus.in_ready     = 1'b1;
    bus.in_fifo_empty = 1'b1;
    bus.in_fifo_data = 8'h00;

    fork
      // Scoreboard monitor.
      forever begin
        @(negedge clk);
        if (rst_n && bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", int'(bus.out_data), -1);
          end else if (bus.in_ready) begin
            check("stream_data", int'(bus.out_data), int'(exp_q.pop_front()));
            npops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
          end else begin
            check("stalled_head", int'(bus.out_data), int'(exp_q[0]));
          end
        end
      end
    join_none

    // Reset hold with a non-empty FIFO.
    push(8'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_take", int'(bus.out_fifo_take), 0);
    end
    check("reset_valid", int'(bus.out_valid), 0);
    check("reset_count", int'(bus.out_word_count), 0);
    check("reset_data", int'(bus.out_data), 0);
    check("reset_busy", int'(bus.out_busy), 0);

    // Single word.
    clear_marks();
    rst_n = 1'b1;
    rel_cyc = cyc;
    #1;
    check("run_gate_take", int'(bus.out_fifo_take), 0);
    ticks(6);
    check("single_takes", ntakes, 1);
    check("first_take_delay", first_take - rel_cyc, 1);
    check("single_latency", first_pop - first_take, 2);
    check("single_pops", npops, 1);
    check("single_count", int'(bus.out_word_count), 1);

    // Streaming 16 words.
    clear_marks();
    t0 = ntakes; p0 = npops;
    for (int i = 0; i < 16; i++) push(8'(i));
    ticks(22);
    check("stream_takes", ntakes - t0, 16);
    check("stream_take_span", last_take - first_take, 15);
    check("stream_pops", npops - p0, 16);
    check("stream_pop_span", last_pop - first_pop, 15);
    check("stream_count", int'(bus.out_word_count), 17);
    check("stream_busy_after", int'(bus.out_busy), 0);

    // Backpressure.
    clear_marks();
    bus.in_ready = 1'b0;
    t0 = ntakes; p0 = npops;
    for (int i = 0; i < 8; i++) push(8'(i));
    ticks(10);
    check("bp_takes", ntakes - t0, 2);
    check("bp_valid", int'(bus.out_valid), 1);
    check("bp_data", int'(bus.out_data), 0);
    check("bp_take_low", int'(bus.out_fifo_take), 0);
    bus.in_ready = 1'b1;
    ticks(14);
    check("bp_total_takes", ntakes - t0, 8);
    check("bp_pops", npops - p0, 8);
    check("bp_pop_span", last_pop - first_pop, 7);
    check("bp_count", int'(bus.out_word_count), 25);

    // Enable gating.
    t0 = ntakes;
    for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
    ticks(4);
    bus.in_enable = 1'b0;
    #1;
    check("en_take_same_cycle", int'(bus.out_fifo_take), 0);
    p0 = ntakes;
    ticks(6);
    check("en_no_new_takes", ntakes, p0);
    check("en_drained_busy", int'(bus.out_busy), 0);
    check("en_drained_count", int'(bus.out_word_count), 25 + (p0 - t0));
    check("en_left_in_fifo", int'(fq.size()) > 0 ? 1 : 0, 1);
    bus.in_enable = 1'b1;
    ticks(16);
    check("en_resume_count", int'(bus.out_word_count), 35);

    // Empty flag gating.
    t0 = ntakes;
    hold_empty = 1'b1;
    push(8'h40);
    push(8'h41);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("empty_take", int'(bus.out_fifo_take), 0);
    end
    check("empty_no_takes", ntakes, t0);
    hold_empty = 1'b0;
    update_empty();
    ticks(6);
    check("empty_release_count", int'(bus.out_word_count), 37);

    // Reset with a full buffer.
    bus.in_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
    ticks(6);
    check("full_valid", int'(bus.out_valid), 1);
    check("full_head", int'(bus.out_data), 8'h20);
    rst_n = 1'b0;
    #1;
    check("midreset_valid", int'(bus.out_valid), 0);
    check("midreset_busy", int'(bus.out_busy), 0);
    check("midreset_count", int'(bus.out_word_count), 0);
    fq.delete();
    exp_q.delete();
    update_empty();
    ticks(2);
    push(8'h30);
    push(8'h31);
    bus.in_ready = 1'b1;
    rst_n = 1'b1;
    ticks(10);
    check("post_reset_count", int'(bus.out_word_count), 2);
    check("post_reset_busy", int'(bus.out_busy), 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side client for `fifo_controller`. It watches the controller's empty flag and issues `take` pulses. It captures the word read from the FIFO storage at the read pointer and presents it on a valid/ready stream output through a 2-entry skid buffer, so it sustains one word per cycle under continuous downstream ready. It sits between the FIFO (controller plus synchronous-read RAM) and any downstream consumer.

## Interface
- `DATA_WIDTH`, 8, width of FIFO words and stream data
- `COUNT_WIDTH`, 16, width of the delivered-word counter

Ports:
- `in_clock`  input  1  single clock for all logic
- `in_reset_n`  input  1  asynchronous, active-low reset
- `in_enable`  input  1  permits new `take` requests when high
- `in_fifo_empty`  input  1  `out_empty` from `fifo_controller`
- `in_fifo_data`  input  DATA_WIDTH  RAM read data; valid the cycle after the `take` that popped it
- `out_fifo_take`  output  1  drives `in_take` of `fifo_controller`
- `out_valid`  output  1  stream word available
- `out_data`  output  DATA_WIDTH  stream word
- `in_ready`  input  1  downstream accepts the word
- `out_busy`  output  1  a word is buffered or in flight
- `out_word_count`  output  COUNT_WIDTH  words delivered since reset; wraps

## Operation
- **Reset values:** all registered state clears asynchronously when `in_reset_n` goes low.
  - `occ` (buffer occupancy, 0..2) = 0, `inflight` = 0, `run` = 0.
  - `out_valid` = 0, `out_data` = 0, `out_busy` = 0, `out_word_count` = 0, `out_fifo_take` = 0.
- **Start-up:** the `run` flop sets on the first clock edge after reset release. No `take` is issued while `run` = 0.
- **Transfer:** `pop = out_valid & in_ready`.
- **Take issue:** `space = 2 - occ - inflight + pop`. `out_fifo_take = run & in_enable & ~in_fifo_empty & (space >= 1)`.
  - `out_fifo_take` is combinational from registers and inputs.
  - It is never asserted while `in_fifo_empty` = 1.
- **In-flight tracking:** `inflight` is next-cycle `out_fifo_take`. When `inflight` = 1, `in_fifo_data` is written into the buffer tail at the clock edge.
- **Buffer:** 2-entry FIFO, head = entry 0.
  - `out_valid = (occ != 0)`; `out_data` = head entry.
  - `occ_next = occ + inflight - pop`, never exceeding 2.
  - Capture and pop in the same cycle: the head shifts out and the new word lands in the correct slot. Order is preserved.
- **Stability rule:** while `out_valid` = 1 and `in_ready` = 0, `out_data` holds constant and `out_valid` stays high.
- **`in_enable` low:** no new takes. A word already in flight is still captured. Buffered words still drain.
- **`out_busy`:** `(occ != 0) | inflight`.
- **`out_word_count`:** increments by 1 on each `pop`; wraps from 2^COUNT_WIDTH-1 to 0.
- **Reset mid-operation:** the buffer and any in-flight word are discarded. The FIFO controller is reset in the same domain, so no word is lost relative to its own pointers.

## Timing
- **First-word latency:**
  - Cycle N: `in_fifo_empty` low (with `in_enable` = 1, `run` = 1) → `out_fifo_take` high in cycle N.
  - Cycle N+1: data is sampled from `in_fifo_data`.
  - Cycle N+2: `out_valid` high.
- **Throughput:** with `in_ready` held high and the FIFO non-empty, `out_fifo_take` stays high every cycle and one word transfers per cycle.
- **Downstream stall:** with `in_ready` low, at most 2 further takes complete. `out_fifo_take` then deasserts until a pop frees space. No word is dropped or duplicated.
- **Empty boundary:** when `in_fifo_empty` rises, takes stop in that same cycle. The last in-flight word is still captured one cycle later.
- **Simultaneous capture, pop and take:** all three in one cycle are legal. Occupancy is unchanged.

## Test plan
- **Reset:** hold `in_reset_n` = 0 with `in_fifo_empty` = 0 → `out_fifo_take` = 0, `out_valid` = 0, `out_word_count` = 0. After release, the first take occurs 1 cycle later.
- **Single word:** preload FIFO with 0xA5, `in_ready` = 1 → exactly one take pulse; `out_valid` high for 1 cycle with `out_data` = 0xA5 two cycles after the take; count = 1.
- **Streaming:** 16 words 0x00..0x0F, `in_ready` = 1 → 16 consecutive take cycles; outputs 0x00..0x0F in order on 16 consecutive cycles; count = 16; `out_busy` low afterwards.
- **Backpressure:** 8 words, `in_ready` = 0 for 10 cycles → exactly 2 takes; `out_data` = 0x00 held stable. Then `in_ready` = 1 → remaining words follow in order without gaps or duplicates.
- **Enable gating:** drop `in_enable` mid-stream → takes stop the same cycle; already-buffered and in-flight words (≤2) still drain. Re-raise `in_enable` → streaming resumes from the next FIFO word.
- **Empty and reset mid-stream:** take attempts while `in_fifo_empty` = 1 produce no pulse. Asserting reset with `occ` = 2 clears `out_valid` immediately, and nothing stale appears after release.
